// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and small helpers used by the top level and its datapath.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    function automatic int unsigned mdu_cnt_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: multiply add-and-shift-right, or restoring divide
// shift-left-compare-subtract. Purely combinational.
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;

    always_comb begin
        addend   = acc_lo_i[0] ? operand_i : '0;
        mul_sum  = {1'b0, acc_hi_i} + {1'b0, addend};
        // Remainder is kept one bit wider during the compare so the shifted-out MSB is not lost.
        rem_sh   = {acc_hi_i, acc_lo_i[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, operand_i};
        rem_ge   = (rem_sh >= {1'b0, operand_i});
        if (is_div_i) begin
            acc_hi_o = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            acc_lo_o = {acc_lo_i[WIDTH-2:0], rem_ge};
        end else begin
            acc_hi_o = mul_sum[WIDTH:1];
            acc_lo_o = {mul_sum[0], acc_lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Operands are made unsigned at accept; signs are restored in the FIX cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = mdu_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             is_div_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic             accept;
    logic             in_signed, in_div, sign1, sign2;
    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign accept = valid_i && (state_q == IDLE);

    always_comb begin
        in_signed = op_is_signed(op_i);
        in_div    = op_is_div(op_i);
        sign1     = in_signed && data1_i[WIDTH-1];
        sign2     = in_signed && data2_i[WIDTH-1];
        abs1      = sign1 ? -data1_i : data1_i;
        abs2      = sign2 ? -data2_i : data2_i;
    end

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i  (is_div_q),
        .acc_hi_i  (acc_hi_q),
        .acc_lo_i  (acc_lo_q),
        .operand_i (operand_q),
        .acc_hi_o  (step_hi),
        .acc_lo_o  (step_lo)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (count_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        busy_o  = (state_q == CALC) || (state_q == FIX);
        done_o  = done_q;
        hi_o    = hi_q;
        lo_o    = lo_q;
    end

    // Remainder follows the dividend's sign; a zero divisor leaves the all-ones quotient unsigned.
    always_comb begin
        prod   = {acc_hi_q, acc_lo_q};
        fix_hi = '0;
        fix_lo = '0;
        if (is_div_q) begin
            fix_lo = neg_res_q ? -acc_lo_q : acc_lo_q;
            fix_hi = neg_rem_q ? -acc_hi_q : acc_hi_q;
        end else begin
            {fix_hi, fix_lo} = neg_res_q ? -prod : prod;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            operand_q <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hi_we_i) hi_q <= wdata_i;
                    if (lo_we_i) lo_q <= wdata_i;
                    if (accept) begin
                        is_div_q  <= in_div;
                        operand_q <= in_div ? abs2 : abs1;
                        acc_hi_q  <= '0;
                        acc_lo_q  <= in_div ? abs1 : abs2;
                        neg_res_q <= (sign1 ^ sign2) && (!in_div || (data2_i != '0));
                        neg_rem_q <= in_div && sign1;
                        count_q   <= CNT_LAST;
                    end
                end
                CALC: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    if (count_q != '0) count_q <= count_q - CNT_W'(1);
                end
                FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
